// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit reorder buffer with writeback, operand lookup and mispredict flush
module reorder_buffer #(
    parameter int ROB_WIDTH = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic                 issue_has_rd,
    output logic [ROB_WIDTH-1:0] issue_tag,
    output logic                 full,
    input  logic                 wb_valid,
    input  logic [ROB_WIDTH-1:0] wb_tag,
    input  logic [31:0]          wb_data,
    input  logic                 wb_mispredict,
    input  logic [31:0]          wb_target,
    input  logic [ROB_WIDTH-1:0] q1_tag,
    input  logic [ROB_WIDTH-1:0] q2_tag,
    output logic                 q1_ready,
    output logic                 q2_ready,
    output logic [31:0]          q1_data,
    output logic [31:0]          q2_data,
    output logic                 to_reg_flag,
    output logic [4:0]           to_reg_rd,
    output logic [31:0]          to_reg_wdata,
    output logic [ROB_WIDTH-1:0] to_reg_tag,
    output logic                 flush,
    output logic [31:0]          flush_pc
);

    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] FULL_COUNT = {1'b1, {ROB_WIDTH{1'b0}}};

    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;
    logic [DEPTH-1:0]     busy;
    logic [DEPTH-1:0]     ready;

    logic [DEPTH-1:0]     has_rd_q;
    logic [DEPTH-1:0]     mis_q;
    logic [4:0]           rd_q     [DEPTH];
    logic [31:0]          data_q   [DEPTH];
    logic [31:0]          target_q [DEPTH];

    logic commit_fire;
    logic flush_now;
    logic issue_fire;
    logic wb_fire;

    assign full      = (count == FULL_COUNT);
    assign issue_tag = tail;

    // A mispredicting commit wipes the queue, so it also swallows any same-edge issue or writeback.
    assign commit_fire = rdy_in && busy[head] && ready[head];
    assign flush_now   = commit_fire && mis_q[head];
    assign issue_fire  = rdy_in && issue_valid && !full && !flush_now;
    assign wb_fire     = rdy_in && wb_valid && busy[wb_tag] && !flush_now;

    // Queue control: pointers, occupancy and per-entry busy/ready flags.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            ready <= '0;
        end else if (flush_now) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            ready <= '0;
        end else if (rdy_in) begin
            if (wb_fire) begin
                ready[wb_tag] <= 1'b1;
            end
            if (commit_fire) begin
                busy[head] <= 1'b0;
                head       <= head + ROB_WIDTH'(1);
            end
            // Issue is written last so it owns the slot if it lands on the one just freed.
            if (issue_fire) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= 1'b0;
                tail        <= tail + ROB_WIDTH'(1);
            end
            case ({issue_fire, commit_fire})
                2'b10:   count <= count + (ROB_WIDTH + 1)'(1);
                2'b01:   count <= count - (ROB_WIDTH + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload; only meaningful while busy, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (issue_fire) begin
            has_rd_q[tail] <= issue_has_rd;
            rd_q[tail]     <= issue_rd;
            mis_q[tail]    <= 1'b0;
        end
        if (wb_fire) begin
            data_q[wb_tag]   <= wb_data;
            mis_q[wb_tag]    <= wb_mispredict;
            target_q[wb_tag] <= wb_target;
        end
    end

    // Registered commit and flush outputs; data fields hold between pulses.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            to_reg_flag  <= 1'b0;
            to_reg_rd    <= '0;
            to_reg_wdata <= '0;
            to_reg_tag   <= '0;
            flush        <= 1'b0;
            flush_pc     <= '0;
        end else begin
            to_reg_flag <= commit_fire && has_rd_q[head] && (rd_q[head] != 5'd0);
            flush       <= flush_now;
            if (commit_fire && has_rd_q[head] && (rd_q[head] != 5'd0)) begin
                to_reg_rd    <= rd_q[head];
                to_reg_wdata <= data_q[head];
                to_reg_tag   <= head;
            end
            if (flush_now) begin
                flush_pc <= target_q[head];
            end
        end
    end

    // Operand lookup for port 1: a same-cycle writeback to the tag takes priority.
    always_comb begin
        q1_ready = 1'b0;
        q1_data  = '0;
        if (wb_valid && (wb_tag == q1_tag)) begin
            q1_ready = 1'b1;
            q1_data  = wb_data;
        end else if (busy[q1_tag] && ready[q1_tag]) begin
            q1_ready = 1'b1;
            q1_data  = data_q[q1_tag];
        end
    end

    // Operand lookup for port 2, same rules as port 1.
    always_comb begin
        q2_ready = 1'b0;
        q2_data  = '0;
        if (wb_valid && (wb_tag == q2_tag)) begin
            q2_ready = 1'b1;
            q2_data  = wb_data;
        end else if (busy[q2_tag] && ready[q2_tag]) begin
            q2_ready = 1'b1;
            q2_data  = data_q[q2_tag];
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed and randomized checks of reorder_buffer against a queue model
module tb_reorder_buffer;

    localparam int W = 3;
    localparam int N = 8;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         rdy_in;
    logic         issue_valid;
    logic [4:0]   issue_rd;
    logic         issue_has_rd;
    logic [W-1:0] issue_tag;
    logic         full;
    logic         wb_valid;
    logic [W-1:0] wb_tag;
    logic [31:0]  wb_data;
    logic         wb_mispredict;
    logic [31:0]  wb_target;
    logic [W-1:0] q1_tag;
    logic [W-1:0] q2_tag;
    logic         q1_ready;
    logic         q2_ready;
    logic [31:0]  q1_data;
    logic [31:0]  q2_data;
    logic         to_reg_flag;
    logic [4:0]   to_reg_rd;
    logic [31:0]  to_reg_wdata;
    logic [W-1:0] to_reg_tag;
    logic         flush;
    logic [31:0]  flush_pc;

    reorder_buffer #(.ROB_WIDTH(W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_has_rd(issue_has_rd),
        .issue_tag(issue_tag), .full(full),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .wb_mispredict(wb_mispredict), .wb_target(wb_target),
        .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_data(q1_data), .q2_data(q2_data),
        .to_reg_flag(to_reg_flag), .to_reg_rd(to_reg_rd), .to_reg_wdata(to_reg_wdata),
        .to_reg_tag(to_reg_tag), .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Reference model: in-flight tags in program order plus per-tag result storage.
    int          mq[$];
    int          m_next;
    bit          m_busy  [N];
    bit          m_ready [N];
    bit          m_hasrd [N];
    bit          m_mis   [N];
    logic [4:0]  m_rd    [N];
    logic [31:0] m_data  [N];
    logic [31:0] m_tgt   [N];
    logic        e_flag;
    logic [4:0]  e_rd;
    logic [31:0] e_wdata;
    logic [W-1:0] e_tag;
    logic        e_flush;
    logic [31:0] e_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_next = 0;
        for (int i = 0; i < N; i++) begin
            m_busy[i]  = 0;
            m_ready[i] = 0;
        end
        e_flag = 0; e_rd = 0; e_wdata = 0; e_tag = 0; e_flush = 0; e_pc = 0;
    endtask

    function automatic logic [32:0] m_look(input logic [W-1:0] t);
        if (wb_valid && wb_tag == t) return {1'b1, wb_data};
        if (m_busy[t] && m_ready[t]) return {1'b1, m_data[t]};
        return 33'd0;
    endfunction

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_has_rd = 0;
        wb_valid = 0; wb_tag = 0; wb_data = 0; wb_mispredict = 0; wb_target = 0;
        rdy_in = 1;
    endtask

    // One clock: inputs set at the falling edge, combinational checks, model advance, registered checks.
    task automatic step();
        logic [32:0] l1, l2;
        bit commit;
        int ct;
        int sz;
        #1;
        l1 = m_look(q1_tag);
        l2 = m_look(q2_tag);
        chk("issue_tag", 32'(issue_tag), 32'(m_next));
        chk("full", 32'(full), 32'(mq.size() == N));
        chk("q1_ready", 32'(q1_ready), 32'(l1[32]));
        chk("q1_data", q1_data, l1[31:0]);
        chk("q2_ready", 32'(q2_ready), 32'(l2[32]));
        chk("q2_data", q2_data, l2[31:0]);
        if (rdy_in) begin
            commit = (mq.size() > 0) && m_ready[mq[0]];
            ct = commit ? mq[0] : 0;
            e_flag = commit && m_hasrd[ct] && (m_rd[ct] != 0);
            if (e_flag) begin
                e_rd = m_rd[ct]; e_wdata = m_data[ct]; e_tag = W'(ct);
            end
            e_flush = commit && m_mis[ct];
            if (e_flush) e_pc = m_tgt[ct];
            if (e_flush) begin
                mq.delete();
                m_next = 0;
                for (int i = 0; i < N; i++) begin
                    m_busy[i] = 0; m_ready[i] = 0;
                end
            end else begin
                sz = mq.size();
                if (wb_valid && m_busy[wb_tag]) begin
                    m_ready[wb_tag] = 1; m_data[wb_tag] = wb_data;
                    m_mis[wb_tag] = wb_mispredict; m_tgt[wb_tag] = wb_target;
                end
                if (commit) begin
                    m_busy[ct] = 0;
                    void'(mq.pop_front());
                end
                if (issue_valid && sz < N) begin
                    mq.push_back(m_next);
                    m_busy[m_next] = 1; m_ready[m_next] = 0; m_mis[m_next] = 0;
                    m_hasrd[m_next] = issue_has_rd; m_rd[m_next] = issue_rd;
                    m_next = (m_next + 1) % N;
                end
            end
        end else begin
            e_flag = 0;
            e_flush = 0;
        end
        @(posedge clk_in);
        #1;
        chk("to_reg_flag", 32'(to_reg_flag), 32'(e_flag));
        chk("to_reg_rd", 32'(to_reg_rd), 32'(e_rd));
        chk("to_reg_wdata", to_reg_wdata, e_wdata);
        chk("to_reg_tag", 32'(to_reg_tag), 32'(e_tag));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("flush_pc", flush_pc, e_pc);
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        idle();
        q1_tag = 0; q2_tag = 0;
        rst_in = 1;
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 0;
        model_clear();
    endtask

    task automatic issue(input logic [4:0] rd, input logic has);
        idle();
        issue_valid = 1; issue_rd = rd; issue_has_rd = has;
        step();
    endtask

    task automatic wb(input int t, input logic [31:0] d, input logic mis, input logic [31:0] tgt);
        idle();
        wb_valid = 1; wb_tag = W'(t); wb_data = d; wb_mispredict = mis; wb_target = tgt;
        step();
    endtask

    initial begin
        idle();
        q1_tag = 0; q2_tag = 0;
        rst_in = 1;
        model_clear();
        #12;
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_issue_tag", 32'(issue_tag), 32'd0);
        chk("rst_to_reg_flag", 32'(to_reg_flag), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_flush_pc", flush_pc, 32'd0);
        chk("rst_to_reg_wdata", to_reg_wdata, 32'd0);
        @(negedge clk_in);
        rst_in = 0;

        // Fill to capacity, try a ninth issue, then drain.
        for (int i = 0; i < N; i++) issue(5'(i + 1), 1'b1);
        #1;
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_issue_tag", 32'(issue_tag), 32'd0);
        issue(5'd31, 1'b1);
        #1;
        chk("fill_ninth_ignored", 32'(full), 32'd1);
        for (int i = 0; i < N; i++) wb(i, 32'h100 + 32'(i), 1'b0, 32'd0);
        idle();
        for (int i = 0; i < 3; i++) step();
        #1;
        chk("drain_full", 32'(full), 32'd0);

        // Out-of-order writeback, in-order commit.
        do_reset();
        issue(5'd5, 1'b1);
        issue(5'd6, 1'b1);
        wb(1, 32'h22, 1'b0, 32'd0);
        wb(0, 32'h11, 1'b0, 32'd0);
        idle(); step();
        chk("order_first_flag", 32'(to_reg_flag), 32'd1);
        chk("order_first_rd", 32'(to_reg_rd), 32'd5);
        chk("order_first_data", to_reg_wdata, 32'h11);
        step();
        chk("order_second_flag", 32'(to_reg_flag), 32'd1);
        chk("order_second_rd", 32'(to_reg_rd), 32'd6);
        chk("order_second_data", to_reg_wdata, 32'h22);
        step();
        chk("order_after_flag", 32'(to_reg_flag), 32'd0);
        chk("order_hold_rd", 32'(to_reg_rd), 32'd6);

        // rd=0 commit: no register write, but the entry retires.
        do_reset();
        issue(5'd0, 1'b1);
        wb(0, 32'h55, 1'b0, 32'd0);
        idle(); step();
        chk("rd0_no_flag", 32'(to_reg_flag), 32'd0);
        q1_tag = 0;
        #1;
        chk("rd0_retired", 32'(q1_ready), 32'd0);
        step();

        // Mispredict on the oldest of three entries.
        do_reset();
        for (int i = 0; i < 3; i++) issue(5'(i + 7), 1'b1);
        wb(0, 32'h77, 1'b1, 32'h1000);
        idle(); step();
        chk("mis_flush", 32'(flush), 32'd1);
        chk("mis_flush_pc", flush_pc, 32'h1000);
        chk("mis_issue_tag", 32'(issue_tag), 32'd0);
        idle(); step();
        chk("mis_flush_one_cycle", 32'(flush), 32'd0);
        wb(1, 32'h88, 1'b0, 32'd0);
        wb(2, 32'h99, 1'b0, 32'd0);
        q1_tag = 1; q2_tag = 2;
        idle(); step();
        chk("mis_stale_wb_q1", 32'(q1_ready), 32'd0);
        chk("mis_no_commit", 32'(to_reg_flag), 32'd0);

        // Same-cycle bypass, then stall with a ready head.
        do_reset();
        for (int i = 0; i < 3; i++) issue(5'(i + 1), 1'b1);
        idle();
        wb_valid = 1; wb_tag = 2; wb_data = 32'hABCD; q1_tag = 2;
        #1;
        chk("bypass_ready", 32'(q1_ready), 32'd1);
        chk("bypass_data", q1_data, 32'hABCD);
        step();
        idle();
        rdy_in = 0;
        wb_valid = 1; wb_tag = 0; wb_data = 32'h1234;
        step();
        wb_valid = 0;
        rdy_in = 1;
        wb(0, 32'h1234, 1'b0, 32'd0);
        rdy_in = 0;
        for (int i = 0; i < 3; i++) step();
        chk("stall_no_commit", 32'(to_reg_flag), 32'd0);
        rdy_in = 1;
        step();
        chk("stall_release_flag", 32'(to_reg_flag), 32'd1);
        chk("stall_release_data", to_reg_wdata, 32'h1234);

        // Asynchronous reset between edges with four busy entries and a ready head.
        do_reset();
        for (int i = 0; i < 4; i++) issue(5'(i + 1), 1'b1);
        wb(0, 32'hBEEF, 1'b0, 32'd0);
        idle();
        #2;
        rst_in = 1;
        #1;
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_issue_tag", 32'(issue_tag), 32'd0);
        chk("arst_flag", 32'(to_reg_flag), 32'd0);
        model_clear();
        @(negedge clk_in);
        rst_in = 0;
        for (int i = 0; i < 3; i++) step();
        chk("arst_no_pulse", 32'(to_reg_flag), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            idle();
            rdy_in        = ($urandom_range(0, 9) != 0);
            issue_valid   = ($urandom_range(0, 9) < 6);
            issue_rd      = 5'($urandom_range(0, 31));
            issue_has_rd  = ($urandom_range(0, 3) != 0);
            wb_valid      = ($urandom_range(0, 9) < 6);
            if (mq.size() > 0 && $urandom_range(0, 4) != 0)
                wb_tag = W'(mq[$urandom_range(0, mq.size() - 1)]);
            else
                wb_tag = W'($urandom_range(0, N - 1));
            wb_data       = $urandom;
            wb_mispredict = ($urandom_range(0, 24) == 0);
            wb_target     = $urandom;
            q1_tag        = ($urandom_range(0, 3) == 0) ? wb_tag : W'($urandom_range(0, N - 1));
            q2_tag        = W'($urandom_range(0, N - 1));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
